seq_mult_8bits: RTL and testbench

Sequential 8x8 unsigned shift-and-add multiplier. It sits directly downstream of the 8-bit ripple-carry adder and consumes its sum/cout each cycle as the partial-product adder. It takes operands x and y with a start pulse and returns a 16-bit product after 8 iteration cycles. It is the team's first clocked datapath built on RCA_8bits.

---
 rtl/seq_mult_8bits_pkg.sv | 17 +
 rtl/seq_mult_8bits_if.sv | 18 +
 rtl/seq_mult_8bits_rca.sv | 29 ++
 rtl/seq_mult_8bits.sv | 121 ++++++++++++
 tb/tb_seq_mult_8bits.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/seq_mult_8bits_pkg.sv
// Shared constants for the sequential 8x8 multiplier: widths, FSM encoding, last iteration.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seq_mult_8bits_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = 3'd7;

endpackage

// File: rtl/seq_mult_8bits_if.sv
// Request/response bundle between a multiplier client and seq_mult_8bits.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while the multiplier is idle or done.
interface seq_mult_8bits_if;
    import seq_mult_8bits_pkg::*;

    logic               start;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    logic [2*WIDTH-1:0] product;
    logic               busy;
    logic               done;

    modport master (output start, output x, output y,
                    input  product, input busy, input done);
    modport slave  (input  start, input x, input y,
                    output product, output busy, output done);
endinterface

// File: rtl/seq_mult_8bits_rca.sv
// 8-bit ripple-carry adder used as the partial-product adder of the multiplier.
// Latency: purely combinational.
// Backpressure: none.
module RCA_8bits
    import seq_mult_8bits_pkg::*;
(
    output logic             cout,
    output logic [WIDTH-1:0] sum,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin
);

    logic [WIDTH:0] carry;

    // Carry ripples bit by bit from cin to cout.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = x[i] ^ y[i] ^ carry[i];
            carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
        end
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_mult_8bits.sv
// Sequential 8x8 unsigned shift-and-add multiplier built on RCA_8bits.
// Latency: 8 cycles from accepted start to the done pulse; one result per 9 cycles at best.
// Backpressure: start is ignored while busy; no output stall, product holds until the next completion.
module seq_mult_8bits
    import seq_mult_8bits_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    seq_mult_8bits_if.slave   bus
);

    state_t             state_q;
    state_t             state_d;
    logic               load;
    logic               step;
    logic               finish;

    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   mreg;
    logic [WIDTH-1:0]   mcand;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] product_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [2*WIDTH-1:0] shifted;

    // Partial product: add the multiplicand only when the current multiplier bit is set.
    assign addend = mreg[0] ? mcand : '0;

    RCA_8bits u_rca (
        .cout (cout),
        .sum  (sum),
        .x    (acc_hi),
        .y    (addend),
        .cin  (1'b0)
    );

    // {cout, sum, mreg} >> 1 keeps the adder carry; only the low 16 bits survive the shift.
    assign shifted = {cout, sum, mreg[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control; start is only honoured in IDLE or DONE.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt == LAST_ITER) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, shift-and-add iteration and result/flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_hi    <= '0;
            mreg      <= '0;
            mcand     <= '0;
            cnt       <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (load) begin
            mcand  <= bus.x;
            mreg   <= bus.y;
            acc_hi <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (step) begin
            acc_hi <= shifted[2*WIDTH-1:WIDTH];
            mreg   <= shifted[WIDTH-1:0];
            cnt    <= cnt + 1'b1;
            if (finish) begin
                product_q <= shifted;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign bus.product = product_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_mult_8bits.sv
// Directed-vector bench for seq_mult_8bits with a queue-based scoreboard.
// Latency: expects done 8 cycles after each accepted start.
// Backpressure: stimulus waits for the scoreboard to drain before the next operation.
module tb_seq_mult_8bits;

    logic clk;
    logic reset_n;
    int   cyc;
    int   tests;
    int   fails;
    int   run_len;

    typedef struct {
        logic [15:0] prod;
        int          acc;
    } exp_t;

    exp_t sb[$];

    seq_mult_8bits_if bus ();

    seq_mult_8bits dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse, checks product, latency and flags.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.done && bus.busy) begin
                tests++;
                fails++;
                $display("FAIL done_busy_overlap: done=%b busy=%b", bus.done, bus.busy);
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: product=%h with empty scoreboard", bus.product);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", bus.product, e.prod);
                    check("latency", 16'(cyc - e.acc), 16'd8);
                    check("busy_len", 16'(run_len), 16'd8);
                end
            end
            if (bus.busy) run_len++;
            else          run_len = 0;
        end else begin
            run_len = 0;
        end
    end

    // Drive one start pulse; the start is accepted at the next rising edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input bit push);
        @(negedge clk);
        bus.x     = a;
        bus.y     = b;
        bus.start = 1'b1;
        if (push) sb.push_back('{prod: exp, acc: cyc + 1});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: %0d results pending, expected 0", name, sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int c;
        cyc       = 0;
        tests     = 0;
        fails     = 0;
        run_len   = 0;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        reset_n   = 1'b0;
        #12;
        check("reset_product", bus.product, 16'h0000);
        check("reset_busy", {15'd0, bus.busy}, 16'd0);
        check("reset_done", {15'd0, bus.done}, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;

        issue(8'hF0, 8'h0F, 16'h0E10, 1'b1);
        drain("f0x0f");
        issue(8'h55, 8'hAA, 16'h3872, 1'b1);
        drain("55xaa");
        issue(8'hFF, 8'hFF, 16'hFE01, 1'b1);
        drain("ffxff");
        issue(8'h00, 8'hC3, 16'h0000, 1'b1);
        drain("00xc3");
        issue(8'h01, 8'h80, 16'h0080, 1'b1);
        drain("01x80");

        // Second start during RUN must be ignored; product holds the old result meanwhile.
        issue(8'd3, 8'd4, 16'h000C, 1'b1);
        @(negedge clk);
        issue(8'd9, 8'd9, 16'h0000, 1'b0);
        check("hold_during_run", bus.product, 16'h0080);
        drain("ignored_start");

        // Reset mid-RUN discards the operation.
        issue(8'hFF, 8'h02, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_product", bus.product, 16'h0000);
        check("abort_busy", {15'd0, bus.busy}, 16'd0);
        check("abort_done", {15'd0, bus.done}, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        issue(8'd2, 8'd5, 16'h000A, 1'b1);
        drain("after_abort");

        // start held high: one result every 9 cycles.
        @(negedge clk);
        c         = cyc;
        bus.x     = 8'd7;
        bus.y     = 8'd6;
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back('{prod: 16'h002A, acc: c + 1 + 9 * i});
        repeat (20) @(negedge clk);
        bus.start = 1'b0;
        drain("held_start");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
